hazard_tracker: RTL and testbench
=================================

# hazard_tracker

- Producer-side companion to the forwarding logic in the pipelined 8-bit processor.
- Records the destination register of every instruction leaving ID and carries it down a three-entry shadow pipeline (EX, MEM, WB).
- Drives the MEM/WB destination and write-enable signals that the forwarding logic compares against.
- Detects load-use hazards that forwarding cannot cover: raises stall, inserts a bubble, and counts stall cycles.

## Interface
- REG_W, 2, register-address width; register 0 is hardwired zero and never tracked.
- CNT_W, 8, width of the saturating stall-cycle counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- ID_valid  in  1  ID stage holds a real instruction.
- ID_RegRs, ID_RegRt  in  REG_W  source register addresses in ID.
- ID_UseRs, ID_UseRt  in  1  instruction actually reads Rs / Rt.
- ID_RegWrite  in  1  instruction writes a register.
- ID_RegRd  in  REG_W  destination register address.
- ID_MemRead  in  1  instruction is a load.
- flush  in  1  squash the instruction in ID (taken branch).
- stat_clr  in  1  synchronous clear of stall_count.
- stall  out  1  hold PC and IF/ID; combinational.
- EX_RegRd, MEM_RegRd, WB_RegRd  out  REG_W  tracked destination per stage.
- EX_RegWrite, MEM_RegWrite, WB_RegWrite  out  1  stage entry valid and writing.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- Each entry holds {vld, rd, ld}.
- The ID entry is written when ID_valid && ID_RegWrite && ID_RegRd != 0; otherwise vld = 0, rd = 0, ld = 0.
- stall = ID_valid && !flush && EX.vld && EX.ld && ((ID_UseRs && ID_RegRs == EX.rd) || (ID_UseRt && ID_RegRt == EX.rd)).
- Every cycle, in this priority order:
  - If flush or stall, EX is loaded with a bubble (all zero).
  - Otherwise EX is loaded from the ID entry.
- MEM <= EX and WB <= MEM advance unconditionally every cycle.
- A load to r0 is never tracked and so never stalls.
- Only a load sitting in EX can cause a stall. A load in MEM or WB is resolved by the forwarding logic.
- A stalled instruction re-presents on the next cycle. EX then holds a bubble, so stall deasserts. The maximum stall per load-use pair is exactly 1 cycle.
- Rs and Rt both matching one load gives a single stall, not two.
- stall_count:
  - stat_clr clears it to 0 and has priority over incrementing.
  - Otherwise it increments on every cycle where stall == 1.
  - It saturates at 2^CNT_W − 1.
- Registered outputs are the vld/rd fields of the EX, MEM and WB entries. XxRegWrite is the entry's vld bit.

## Timing
- Reset (rst_n low, asynchronous):
  - All entries are cleared to 0.
  - All XxRegRd and XxRegWrite outputs are 0.
  - stall_count is 0.
  - stall is 0, since it depends on EX.vld.
- Release of reset is synchronous to clk. The first capture happens on the first rising edge with rst_n high.
- Latency:
  - An instruction in ID at edge N appears on EX_* after edge N.
  - It appears on MEM_* after edge N+1.
  - It appears on WB_* after edge N+2.
- stall is combinational from ID_* and the registered EX entry. It is valid in the same cycle and has no clk-to-stall register.
- flush and stall in the same cycle: flush wins, stall = 0, and one bubble is inserted.
- Reset asserted mid-stall: all state clears immediately. stall drops in the same cycle, without waiting for a clk edge.
- stat_clr in the same cycle as a stall: the counter becomes 0. The stall cycle is not counted.

## Test plan
- Tracking, no hazard:
  - Stimulus: ALU write r2 in ID at cycle 0, then NOPs.
  - Required: EX_RegRd=2 / EX_RegWrite=1 at cycle 1; MEM_* at cycle 2; WB_* at cycle 3; all zero at cycle 4; stall never 1.
- Load-use:
  - Stimulus: load r1 at cycle 0; at cycle 1 ID holds an instruction with Rs=1, UseRs=1.
  - Required: stall=1 in cycle 1 only; EX_RegWrite=0 (bubble) in cycle 2; the dependent instruction enters EX at cycle 3; stall_count=1.
- Non-stall cases:
  - Stimulus 1: load r1 followed by an instruction with Rt=1 and UseRt=0. Required: stall=0.
  - Stimulus 2: load r0 followed by a use of r0. Required: stall=0 and nothing tracked.
- Flush priority:
  - Stimulus: the load-use condition from the load-use scenario plus flush=1 in cycle 1.
  - Required: stall=0; EX bubble at cycle 2; stall_count unchanged.
- Saturation and clear:
  - Stimulus: with CNT_W=2, force 5 stall cycles, then pulse stat_clr together with one more stall cycle.
  - Required: stall_count saturates at 3, then reads 0 after the clear edge.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while EX holds a load and stall=1.
  - Required: stall and all outputs go to 0 before the next clk edge; the pipeline is empty after release.

Source files
------------

// File: rtl/hazard_tracker.sv
// Destination-register shadow pipeline (EX/MEM/WB) for the forwarding unit, with
// load-use stall detection and a saturating stall-cycle counter.
module hazard_tracker #(
  parameter int REG_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_RegRs,
  input  logic [REG_W-1:0] ID_RegRt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_RegWrite,
  input  logic [REG_W-1:0] ID_RegRd,
  input  logic             ID_MemRead,
  input  logic             flush,
  input  logic             stat_clr,
  output logic             stall,
  output logic [REG_W-1:0] EX_RegRd,
  output logic [REG_W-1:0] MEM_RegRd,
  output logic [REG_W-1:0] WB_RegRd,
  output logic             EX_RegWrite,
  output logic             MEM_RegWrite,
  output logic             WB_RegWrite,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             ld;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t idEntry;
  entry_t exEntry;
  entry_t memEntry;
  entry_t wbEntry;
  logic   rsHit;
  logic   rtHit;

  // Writes to r0 are dropped here, so a load to r0 can never cause a stall.
  always_comb begin
    idEntry = '0;
    if (ID_valid && ID_RegWrite && (ID_RegRd != '0)) begin
      idEntry.vld = 1'b1;
      idEntry.rd  = ID_RegRd;
      idEntry.ld  = ID_MemRead;
    end
  end

  // stall holds PC and IF/ID for one cycle; the EX bubble it inserts clears it.
  assign rsHit = ID_UseRs && (ID_RegRs == exEntry.rd);
  assign rtHit = ID_UseRt && (ID_RegRt == exEntry.rd);
  assign stall = ID_valid && !flush && exEntry.vld && exEntry.ld && (rsHit || rtHit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exEntry  <= '0;
      memEntry <= '0;
      wbEntry  <= '0;
    end else begin
      exEntry  <= (flush || stall) ? entry_t'('0) : idEntry;
      memEntry <= exEntry;
      wbEntry  <= memEntry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign EX_RegRd     = exEntry.rd;
  assign MEM_RegRd    = memEntry.rd;
  assign WB_RegRd     = wbEntry.rd;
  assign EX_RegWrite  = exEntry.vld;
  assign MEM_RegWrite = memEntry.vld;
  assign WB_RegWrite  = wbEntry.vld;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker (REG_W=2, CNT_W=2): driver pushes hand-computed
// per-cycle observations, a negedge monitor pops and compares them.
module tb_hazard_tracker;

  localparam int REG_W = 2;
  localparam int CNT_W = 2;
  localparam int OBS_W = 12;
  localparam int IN_W  = 13;
  localparam logic [IN_W-1:0] NOP = '0;

  logic             clk;
  logic             rst_n;
  logic             ID_valid;
  logic [REG_W-1:0] ID_RegRs;
  logic [REG_W-1:0] ID_RegRt;
  logic             ID_UseRs;
  logic             ID_UseRt;
  logic             ID_RegWrite;
  logic [REG_W-1:0] ID_RegRd;
  logic             ID_MemRead;
  logic             flush;
  logic             stat_clr;
  logic             stall;
  logic [REG_W-1:0] EX_RegRd;
  logic [REG_W-1:0] MEM_RegRd;
  logic [REG_W-1:0] WB_RegRd;
  logic             EX_RegWrite;
  logic             MEM_RegWrite;
  logic             WB_RegWrite;
  logic [CNT_W-1:0] stall_count;

  logic [OBS_W-1:0] exp_q[$];
  int               tag_q[$];
  int               vectors;
  int               miscompares;
  int               cyc_no;

  hazard_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_RegWrite(ID_RegWrite),
    .ID_RegRd(ID_RegRd), .ID_MemRead(ID_MemRead),
    .flush(flush), .stat_clr(stat_clr), .stall(stall),
    .EX_RegRd(EX_RegRd), .MEM_RegRd(MEM_RegRd), .WB_RegRd(WB_RegRd),
    .EX_RegWrite(EX_RegWrite), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .stall_count(stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [IN_W-1:0] mk(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                                         input logic urs, input logic urt, input logic rw,
                                         input logic [1:0] rd, input logic mr, input logic fl,
                                         input logic clr);
    return {v, rs, rt, urs, urt, rw, rd, mr, fl, clr};
  endfunction

  function automatic logic [OBS_W-1:0] ob(input logic st, input logic exW, input logic [1:0] exRd,
                                          input logic memW, input logic [1:0] memRd,
                                          input logic wbW, input logic [1:0] wbRd,
                                          input logic [1:0] cnt);
    return {st, exW, exRd, memW, memRd, wbW, wbRd, cnt};
  endfunction

  function automatic logic [OBS_W-1:0] actual();
    return {stall, EX_RegWrite, EX_RegRd, MEM_RegWrite, MEM_RegRd, WB_RegWrite, WB_RegRd, stall_count};
  endfunction

  task automatic apply(input logic [IN_W-1:0] in);
    {ID_valid, ID_RegRs, ID_RegRt, ID_UseRs, ID_UseRt, ID_RegWrite,
     ID_RegRd, ID_MemRead, flush, stat_clr} = in;
  endtask

  // driver: one cycle of stimulus plus the observation expected in that cycle
  task automatic cyc(input logic [IN_W-1:0] in, input logic [OBS_W-1:0] e);
    @(posedge clk);
    #1;
    apply(in);
    exp_q.push_back(e);
    tag_q.push_back(cyc_no);
    cyc_no++;
  endtask

  task automatic check_now(input string name, input logic [OBS_W-1:0] e);
    logic [OBS_W-1:0] a;
    a = actual();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s {stall,exW,exRd,memW,memRd,wbW,wbRd,cnt} got=%b required=%b", name, a, e);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OBS_W-1:0] e;
      logic [OBS_W-1:0] a;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle%0d {stall,exW,exRd,memW,memRd,wbW,wbRd,cnt} got=%b required=%b", t, a, e);
      end
    end
  end

  logic [IN_W-1:0] instI;

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc_no = 0;
    rst_n = 1'b0;
    apply(NOP);
    #12;
    check_now("reset_state", ob(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // tracking, no hazard: ALU write r2
    cyc(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(NOP, ob(0, 1, 2, 0, 0, 0, 0, 0));
    cyc(NOP, ob(0, 0, 0, 1, 2, 0, 0, 0));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 2, 0));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 0));

    // load-use: load r1, then reader of r1 (writes r3) stalls once
    cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 1, 0, 1, 0, 1, 3, 0, 0, 0), ob(1, 1, 1, 0, 0, 0, 0, 0));
    cyc(mk(1, 1, 0, 1, 0, 1, 3, 0, 0, 0), ob(0, 0, 0, 1, 1, 0, 0, 1));
    cyc(NOP, ob(0, 1, 3, 0, 0, 1, 1, 1));
    cyc(NOP, ob(0, 0, 0, 1, 3, 0, 0, 1));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 3, 1));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 1));

    // no stall: Rt matches but is not used
    cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(1, 2, 1, 1, 0, 1, 2, 0, 0, 0), ob(0, 1, 1, 0, 0, 0, 0, 1));
    cyc(NOP, ob(0, 1, 2, 1, 1, 0, 0, 1));
    cyc(NOP, ob(0, 0, 0, 1, 2, 1, 1, 1));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 2, 1));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 1));

    // no stall: load r0 is never tracked
    cyc(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 1));

    // Rs and Rt both match one load: a single stall cycle
    cyc(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(1, 2, 2, 1, 1, 0, 0, 0, 0, 0), ob(1, 1, 2, 0, 0, 0, 0, 1));
    cyc(mk(1, 2, 2, 1, 1, 0, 0, 0, 0, 0), ob(0, 0, 0, 1, 2, 0, 0, 2));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 2, 2));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 2));

    // flush beats stall
    cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 2));
    cyc(mk(1, 1, 0, 1, 0, 1, 3, 0, 1, 0), ob(0, 1, 1, 0, 0, 0, 0, 2));
    cyc(NOP, ob(0, 0, 0, 1, 1, 0, 0, 2));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 1, 2));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 2));

    // saturation: clear, then chained "load r1 reading r1" gives a stall every other cycle
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ob(0, 0, 0, 0, 0, 0, 0, 2));
    instI = mk(1, 1, 0, 1, 0, 1, 1, 1, 0, 0);
    cyc(instI, ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(instI, ob(1, 1, 1, 0, 0, 0, 0, 0));
    cyc(instI, ob(0, 0, 0, 1, 1, 0, 0, 1));
    cyc(instI, ob(1, 1, 1, 0, 0, 1, 1, 1));
    cyc(instI, ob(0, 0, 0, 1, 1, 0, 0, 2));
    cyc(instI, ob(1, 1, 1, 0, 0, 1, 1, 2));
    cyc(instI, ob(0, 0, 0, 1, 1, 0, 0, 3));
    cyc(instI, ob(1, 1, 1, 0, 0, 1, 1, 3));
    cyc(instI, ob(0, 0, 0, 1, 1, 0, 0, 3));
    cyc(instI, ob(1, 1, 1, 0, 0, 1, 1, 3));
    cyc(instI, ob(0, 0, 0, 1, 1, 0, 0, 3));
    // stat_clr together with a stall cycle: counter reads 0 afterwards
    cyc(mk(1, 1, 0, 1, 0, 1, 1, 1, 0, 1), ob(1, 1, 1, 0, 0, 1, 1, 3));
    cyc(NOP, ob(0, 0, 0, 1, 1, 0, 0, 0));
    cyc(NOP, ob(0, 0, 0, 0, 0, 1, 1, 0));
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 0));

    // async reset while a load sits in EX and stall is high; build a nonzero count first
    cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 0), ob(1, 1, 1, 0, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0), ob(0, 0, 0, 1, 1, 0, 0, 1));
    cyc(mk(1, 1, 0, 1, 0, 1, 2, 0, 0, 0), ob(1, 1, 1, 0, 0, 1, 1, 1));
    @(negedge clk);
    #2;
    check_now("pre_reset_stall", ob(1, 1, 1, 0, 0, 1, 1, 1));
    rst_n = 1'b0;
    #1;
    check_now("async_reset_midcycle", ob(0, 0, 0, 0, 0, 0, 0, 0));
    apply(NOP);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc(NOP, ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 2, 0, 1, 0, 1, 3, 0, 0, 0), ob(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(NOP, ob(0, 1, 3, 0, 0, 0, 0, 0));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending observations required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
